// File: rtl/sdr_qsram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sdr_qsram_ctrl_pkg
//   Shared definitions for the SDR quad-SRAM host controller: default widths and
//   timing constants (also used by the SRAM device model), the controller state
//   encoding and a counter-width helper.
// -----------------------------------------------------------------------------
package sdr_qsram_ctrl_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH       = 30;
  localparam int unsigned DEFAULT_DATA_WIDTH       = 9;
  localparam int unsigned DEFAULT_READ_LATENCY     = 2;
  localparam int unsigned DEFAULT_REFRESH_INTERVAL = 780;
  localparam int unsigned DEFAULT_REFRESH_CYCLES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_DONE = 3'd4,
    ST_REFRESH = 3'd5
  } state_e;

  // Width of a down/up counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdr_qsram_refresh_timer.sv
// -----------------------------------------------------------------------------
// sdr_qsram_refresh_timer
//   Free-running counter 0..REFRESH_INTERVAL-1 that raises a sticky refresh
//   request each time it reaches its last value. The counter never stops, so the
//   refresh period is independent of how long the controller takes to serve it.
//
// Ports
//   Clock    in   single clock, rising edge
//   Reset    in   asynchronous, active-high
//   Clear    in   pending acknowledge (controller entering refresh)
//   Pending  out  refresh requested and not yet acknowledged
// -----------------------------------------------------------------------------
module sdr_qsram_refresh_timer
  import sdr_qsram_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Pending
);

  localparam int unsigned        CW   = cnt_width(REFRESH_INTERVAL);
  localparam logic [CW-1:0]      LAST = CW'(REFRESH_INTERVAL - 1);

  logic [CW-1:0] count_q, count_d;
  logic          pending_q, pending_d;
  logic          wrap;

  // NOTE: every signal assigned in always_comb gets a default on every path
  // (here by straight-line assignment) so no latch can be inferred.
  always_comb begin
    wrap      = (count_q == LAST);
    count_d   = wrap ? '0 : count_q + 1'b1;
    // A wrap in the same cycle as the acknowledge still leaves a request set.
    pending_d = (pending_q & ~Clear) | wrap;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of process ordering.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign Pending = pending_q;

endmodule

// File: rtl/sdr_qsram_ctrl.sv
// -----------------------------------------------------------------------------
// sdr_qsram_ctrl
//   Host-side controller for an SDR quad SRAM. Accepts single-beat read/write
//   requests on a valid/ready port, drives the SRAM command pins and the
//   bidirectional data bus, and interleaves periodic refresh bursts.
//
// Ports
//   Clock, Reset        single clock; asynchronous active-high reset
//   ReqValid/ReqReady   request handshake (accepted when both high at an edge)
//   ReqWrite            1 = write, 0 = read
//   ReqAddress/ReqData  request address / write data
//   RspValid/RspData    one-cycle read strobe; data held until the next strobe
//   RefreshBusy         refresh burst in progress
//   MemData             SRAM data bus, driven only in the write-command cycle
//   MemAddress          SRAM address (holds its last value between commands)
//   MemEnable/MemRead/MemWrite/MemRefresh  SRAM strobes
//
// All outputs are flops loaded from the next-state decode, so they line up with
// the state they belong to and nothing on Req* reaches an output combinationally.
// -----------------------------------------------------------------------------
module sdr_qsram_ctrl
  import sdr_qsram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH       = DEFAULT_DATA_WIDTH,
  parameter int unsigned READ_LATENCY     = DEFAULT_READ_LATENCY,
  parameter int unsigned REFRESH_INTERVAL = DEFAULT_REFRESH_INTERVAL,
  parameter int unsigned REFRESH_CYCLES   = DEFAULT_REFRESH_CYCLES
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddress,
  input  logic [DATA_WIDTH-1:0] ReqData,
  output logic                  RspValid,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RefreshBusy,
  inout  wire  [DATA_WIDTH-1:0] MemData,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic                  MemEnable,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  MemRefresh
);

  if (READ_LATENCY < 1) begin : g_bad_read_latency
    $fatal(1, "sdr_qsram_ctrl: READ_LATENCY must be at least 1");
  end
  if (REFRESH_CYCLES < 1) begin : g_bad_refresh_cycles
    $fatal(1, "sdr_qsram_ctrl: REFRESH_CYCLES must be at least 1");
  end
  if (REFRESH_INTERVAL <= REFRESH_CYCLES + READ_LATENCY + 4) begin : g_bad_interval
    $fatal(1, "sdr_qsram_ctrl: REFRESH_INTERVAL too short for one transaction plus a burst");
  end

  localparam int unsigned WAIT_W = cnt_width(READ_LATENCY);
  localparam int unsigned REF_W  = cnt_width(REFRESH_CYCLES);

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [REF_W-1:0]      burst_q, burst_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  enable_q, enable_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic                  refresh_q, refresh_d;
  logic                  drive_q, drive_d;
  logic                  accept;
  logic                  clear;
  logic                  pending;

  sdr_qsram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (clear),
    .Pending (pending)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    accept     = 1'b0;
    clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A handshake already advertised by ReqReady is honoured even if the
        // refresh request rose on that same edge; refresh then follows it.
        if (ReqValid && ready_q) begin
          accept  = 1'b1;
          state_d = ReqWrite ? ST_WR_CMD : ST_RD_CMD;
        end else if (pending) begin
          clear   = 1'b1;
          burst_d = REF_W'(REFRESH_CYCLES - 1);
          state_d = ST_REFRESH;
        end
      end
      ST_WR_CMD: state_d = ST_IDLE;
      ST_RD_CMD: begin
        wait_d  = WAIT_W'(READ_LATENCY - 1);
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // Last wait cycle is the one in which the device presents its data.
        if (wait_q == '0) begin
          rsp_data_d = MemData;
          state_d    = ST_RD_DONE;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RD_DONE: state_d = ST_IDLE;
      ST_REFRESH: begin
        if (burst_q == '0) state_d = ST_IDLE;
        else               burst_d = burst_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      addr_d  = ReqAddress;
      wdata_d = ReqData;
    end

    ready_d     = (state_d == ST_IDLE) && !pending;
    rsp_valid_d = (state_d == ST_RD_DONE);
    write_d     = (state_d == ST_WR_CMD);
    read_d      = (state_d == ST_RD_CMD);
    refresh_d   = (state_d == ST_REFRESH);
    enable_d    = write_d | read_d | refresh_d;
    drive_d     = write_d;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      enable_q    <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      refresh_q   <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      enable_q    <= enable_d;
      read_q      <= read_d;
      write_q     <= write_d;
      refresh_q   <= refresh_d;
      drive_q     <= drive_d;
    end
  end

  // Bus enable is a flop cleared by the async reset, so reset releases the bus
  // immediately.
  assign MemData     = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign ReqReady    = ready_q;
  assign RspValid    = rsp_valid_q;
  assign RspData     = rsp_data_q;
  assign RefreshBusy = refresh_q;
  assign MemAddress  = addr_q;
  assign MemEnable   = enable_q;
  assign MemRead     = read_q;
  assign MemWrite    = write_q;
  assign MemRefresh  = refresh_q;

endmodule

// File: tb/tb_sdr_qsram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdr_qsram_ctrl
//   Scoreboard bench for sdr_qsram_ctrl with an SRAM device model on the pins.
//   Accepted requests push expected pin commands and read responses; a monitor
//   pops them whenever the DUT shows a command or RspValid.
// -----------------------------------------------------------------------------
module tb_sdr_qsram_ctrl;

  localparam int AW = 30;
  localparam int DW = 9;
  localparam int RL = 2;
  localparam int RI = 20;
  localparam int RC = 4;

  typedef struct {
    int            cyc;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          refresh_busy;
  wire  [DW-1:0] mem_data;
  logic [AW-1:0] mem_address;
  logic          mem_enable;
  logic          mem_read;
  logic          mem_write;
  logic          mem_refresh;

  logic          dev_drive = 1'b0;
  logic [DW-1:0] dev_data  = '0;
  assign mem_data = dev_drive ? dev_data : {DW{1'bz}};

  sdr_qsram_ctrl #(
    .ADDR_WIDTH       (AW),
    .DATA_WIDTH       (DW),
    .READ_LATENCY     (RL),
    .REFRESH_INTERVAL (RI),
    .REFRESH_CYCLES   (RC)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .ReqValid    (req_valid),
    .ReqReady    (req_ready),
    .ReqWrite    (req_write),
    .ReqAddress  (req_address),
    .ReqData     (req_data),
    .RspValid    (rsp_valid),
    .RspData     (rsp_data),
    .RefreshBusy (refresh_busy),
    .MemData     (mem_data),
    .MemAddress  (mem_address),
    .MemEnable   (mem_enable),
    .MemRead     (mem_read),
    .MemWrite    (mem_write),
    .MemRefresh  (mem_refresh)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since reset release.
  int cyc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int checks = 0;
  int fails  = 0;

  cmd_t          cmd_q[$];
  rsp_t          rsp_q[$];
  rsp_t          dev_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] dev_mem [logic [AW-1:0]];
  logic [DW-1:0] last_rsp = '0;

  bit idle_phase = 1'b0;
  bit in_burst   = 1'b0;
  int burst_start;
  int last_burst_start = -1;
  int last_due = -1;
  int bursts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Contents of a never-written SRAM location, as returned by the device model.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [DW-1:0] seed;
    seed = 9'h0A5;
    return a[DW-1:0] ^ seed;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DW-1:0] dev_read(input logic [AW-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor + device model, evaluated on the falling edge.
  // ---------------------------------------------------------------------------
  task automatic monitor_cycle();
    cmd_t c;
    rsp_t r;
    int   due;

    // Reference model: an accepted request fixes its command cycle and, for a
    // read, its response cycle and data.
    if (req_valid && req_ready) begin
      if (req_write) begin
        ref_mem[req_address] = req_data;
        cmd_q.push_back('{cyc + 1, 1'b1, req_address, req_data});
      end else begin
        cmd_q.push_back('{cyc + 1, 1'b0, req_address, '0});
        rsp_q.push_back('{cyc + RL + 2, ref_read(req_address)});
      end
    end

    check("enable_matches_strobes", mem_enable, mem_read | mem_write | mem_refresh);
    check("busy_matches_refresh", refresh_busy, mem_refresh);

    if (mem_read || mem_write) begin
      check("cmd_outstanding", cmd_q.size() != 0, 1);
      if (cmd_q.size() != 0) begin
        c = cmd_q.pop_front();
        check("cmd_cycle", cyc, c.cyc);
        check("cmd_is_write", mem_write, c.wr);
        check("cmd_address", mem_address, c.addr);
        if (c.wr) check("write_bus_data", mem_data, c.data);
      end
    end

    if (!mem_write && !dev_drive) check("bus_released", mem_data, {DW{1'bz}});

    if (rsp_valid) begin
      check("rsp_outstanding", rsp_q.size() != 0, 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rsp_cycle", cyc, r.cyc);
        check("rsp_data", rsp_data, r.data);
        last_rsp = r.data;
      end
    end else begin
      check("rsp_data_held", rsp_data, last_rsp);
    end

    if (mem_refresh) begin
      check("refresh_exclusive", {mem_read, mem_write, req_ready}, 3'b000);
      if (!in_burst) begin
        in_burst    = 1'b1;
        burst_start = cyc;
        bursts++;
        // Timer request becomes visible in cycle k*RI; an idle controller
        // starts the burst one cycle later, a busy one up to RL+4 later.
        due = ((cyc - 1) / RI) * RI;
        check("refresh_window", (cyc - due >= 1) && (cyc - due <= RL + 4), 1);
        check("refresh_once_per_period", due != last_due, 1);
        last_due         = due;
        last_burst_start = cyc;
        if (idle_phase) check("refresh_idle_start_phase", cyc % RI, 1);
      end
    end else if (in_burst) begin
      in_burst = 1'b0;
      check("refresh_burst_length", cyc - burst_start, RC);
    end

    // Device model: store writes, present read data for one cycle, RL cycles
    // after the read command.
    if (mem_enable && mem_write) dev_mem[mem_address] = mem_data;
    if (mem_enable && mem_read) dev_q.push_back('{cyc + RL, dev_read(mem_address)});
    dev_drive = 1'b0;
    if (dev_q.size() != 0 && dev_q[0].cyc == cyc) begin
      dev_data  = dev_q[0].data;
      dev_drive = 1'b1;
      void'(dev_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) monitor_cycle();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at posedge + 1).
  // ---------------------------------------------------------------------------
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int acc);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    acc  = -1;
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_data    = d;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        acc  = cyc;
      end
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        checks++;
        fails++;
        $display("FAIL req_accept_timeout: no ReqReady within %0d cycles", n);
        done = 1'b1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    do @(negedge clk); while (cyc % RI != ph);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || rsp_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_outstanding", cmd_q.size() + rsp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},    req_ready,    0);
    check({tag, "_rsp_valid"},    rsp_valid,    0);
    check({tag, "_rsp_data"},     rsp_data,     0);
    check({tag, "_refresh_busy"}, refresh_busy, 0);
    check({tag, "_mem_address"},  mem_address,  0);
    check({tag, "_mem_strobes"},  {mem_enable, mem_read, mem_write, mem_refresh}, 4'b0000);
    check({tag, "_mem_data_z"},   mem_data,     {DW{1'bz}});
  endtask

  task automatic flush_for_reset();
    cmd_q.delete();
    rsp_q.delete();
    dev_q.delete();
    dev_drive        = 1'b0;
    in_burst         = 1'b0;
    last_due         = -1;
    last_rsp         = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [AW-1:0] pool [6];
    int acc0, acc1, acc2, b0;

    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_address = '0;
    req_data = '0;
    #1 rst = 1'b1;
    #3 check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por_clocked");
    @(posedge clk);
    #2 rst = 1'b0;

    // Idle after reset: ready from cycle 1, no strobes, two refresh bursts
    // exactly one interval apart.
    idle_phase = 1'b1;
    b0 = bursts;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("idle_req_ready", req_ready, 1);
      check("idle_strobes", {mem_enable, mem_read, mem_write, mem_refresh}, 4'b0000);
    end
    while (cyc < 50) @(negedge clk);
    check("idle_refresh_burst_count", bursts - b0, 2);
    idle_phase = 1'b0;
    @(posedge clk);
    #1;

    // Directed write then read-back.
    wait_phase(6);
    issue(1'b1, 30'h0000_0123, 9'h1A5, acc0);
    while (cyc < acc0 + 2) @(negedge clk);
    check("write_ready_two_cycles_later", req_ready, 1);
    @(posedge clk);
    #1;
    issue(1'b0, 30'h0000_0123, 9'h000, acc1);
    drain();

    // Random traffic over a small address pool so reads hit earlier writes.
    for (int i = 0; i < 6; i++) pool[i] = AW'($urandom);
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], DW'($urandom), acc0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    // Read in flight as refresh becomes pending, with a second request held.
    wait_phase(17);
    issue(1'b0, pool[0], 9'h000, acc1);
    issue(1'b1, pool[1], 9'h0C3, acc2);
    check("held_req_after_refresh", (last_burst_start > acc1) && (acc2 > last_burst_start + RC - 1), 1);
    drain();

    // Reset during RD_WAIT aborts the read and releases everything at once.
    wait_phase(6);
    issue(1'b0, 30'h0000_0123, 9'h000, acc1);
    @(posedge clk);
    #2 rst = 1'b1;
    flush_for_reset();
    #1 check_reset_outputs("mid_read_reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    issue(1'b0, 30'h0000_0123, 9'h000, acc1);
    issue(1'b0, pool[1], 9'h000, acc2);
    drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
